// File: rtl/axi_rd_arbiter.sv
// Two-port AXI read arbiter: shares one AR/R channel between instruction fetch (port 0)
// and data load (port 1). Define RR_ARB_EN for round-robin instead of fixed port-1 priority.
module axi_rd_arbiter #(
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [3:0]  ID_P0     = 4'd0,
  parameter logic [3:0]  ID_P1     = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [1:0]  p0_size,
  output logic        p0_addr_ok,
  output logic        p0_data_ok,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [1:0]  p1_size,
  output logic        p1_addr_ok,
  output logic        p1_data_ok,
  output logic [31:0] p1_rdata,

  input  logic        wr_busy,

  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arsize,
  output logic        m_arvalid,
  input  logic        m_arready,

  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,

  output logic        rid_err
);

  localparam int CW = 3;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic [CW-1:0] cnt0, cnt1;
  logic          slot_free, elig0, elig1, grant0, grant1;
  logic          r_hs, ret0, ret1, bad_rid, uflow0, uflow1;

  // Every R beat is single-beat, so the last flag carries no information here.
  logic unused_rlast;
  assign unused_rlast = m_rlast;

  assign slot_free = !m_arvalid || m_arready;
  assign elig0     = p0_req && (cnt0 < MAX_CNT);
  assign elig1     = p1_req && (cnt1 < MAX_CNT) && !wr_busy;

`ifdef RR_ARB_EN
  logic rr_ptr;  // last granted port

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free) begin
      if (elig0 && elig1) begin
        grant0 = rr_ptr;
        grant1 = !rr_ptr;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (grant1) rr_ptr <= 1'b1;
    else if (grant0) rr_ptr <= 1'b0;
  end
`else
  assign grant1 = slot_free && elig1;
  assign grant0 = slot_free && elig0 && !elig1;
`endif

  assign p0_addr_ok = grant0;
  assign p1_addr_ok = grant1;

  // AR channel register: loads on grant, holds while stalled, drops once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      m_arid    <= 4'd0;
      m_araddr  <= 32'd0;
      m_arsize  <= 3'd0;
    end else if (grant1) begin
      m_arvalid <= 1'b1;
      m_arid    <= ID_P1;
      m_araddr  <= p1_addr;
      m_arsize  <= {1'b0, p1_size};
    end else if (grant0) begin
      m_arvalid <= 1'b1;
      m_arid    <= ID_P0;
      m_araddr  <= p0_addr;
      m_arsize  <= {1'b0, p0_size};
    end else if (slot_free) begin
      m_arvalid <= 1'b0;
    end
  end

  assign r_hs    = m_rvalid && m_rready;
  assign ret0    = r_hs && (m_rid == ID_P0);
  assign ret1    = r_hs && (m_rid == ID_P1) && !ret0;
  assign bad_rid = r_hs && !ret0 && !ret1;
  assign uflow0  = ret0 && (cnt0 == '0);
  assign uflow1  = ret1 && (cnt1 == '0);

  // A return against an empty counter is an underflow: the counter saturates at zero.
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    if (inc && !dec)                return cnt + CW'(1);
    if (dec && !inc && cnt != '0)   return cnt - CW'(1);
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0       <= '0;
      cnt1       <= '0;
      m_rready   <= 1'b0;
      p0_data_ok <= 1'b0;
      p1_data_ok <= 1'b0;
      p0_rdata   <= 32'd0;
      p1_rdata   <= 32'd0;
      rid_err    <= 1'b0;
    end else begin
      cnt0       <= next_cnt(cnt0, grant0, ret0);
      cnt1       <= next_cnt(cnt1, grant1, ret1);
      m_rready   <= 1'b1;
      p0_data_ok <= ret0;
      p1_data_ok <= ret1;
      if (ret0) p0_rdata <= m_rdata;
      if (ret1) p1_rdata <= m_rdata;
      if (bad_rid || uflow0 || uflow1) rid_err <= 1'b1;
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI read channel (AR/R) between two SRAM-like read requesters: port 0 (instruction fetch) and port 1 (data load).
- Sits between the core's fetch/memory stages and the AXI read side of the SRAM–AXI bridge.
- Supports multiple outstanding reads per port, tracked by ARID.
- Holds data reads while the write channel is busy to keep load/store ordering.

Parameters:
- MAX_OUTST, 2: maximum in-flight reads per port (1..7); counter width CW = 3.
- ID_P0, 4'd0: ARID used for port 0.
- ID_P1, 4'd1: ARID used for port 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- p0_req / p1_req  in  1  read request.
- p0_addr / p1_addr  in  32  byte address.
- p0_size / p1_size  in  2  log2 bytes.
- p0_addr_ok / p1_addr_ok  out  1  request accepted this cycle.
- p0_data_ok / p1_data_ok  out  1  read data valid.
- p0_rdata / p1_rdata  out  32  read data.
- wr_busy  in  1  write channel has an unfinished write; blocks port 1.
- m_arid  out  4;  m_araddr  out  32;  m_arsize  out  3;  m_arvalid  out  1;  m_arready  in  1.
- m_rid  in  4;  m_rdata  in  32;  m_rlast  in  1;  m_rvalid  in  1;  m_rready  out  1.
- rid_err  out  1  sticky: R beat with unknown RID.

Behaviour:
- Reset (async, rst_n=0): m_arvalid=0, m_arid=0, m_araddr=0, m_arsize=0, m_rready=0, both counters=0, p*_data_ok=0, p*_rdata=0, rid_err=0, RR pointer=0. All in-flight transactions are discarded; the interconnect is reset together with the block.
- m_rready is 1 from the first cycle after reset release. The block never back-pressures R.
- Port eligibility:
  - Port 0 eligible when p0_req=1 and cnt0<MAX_OUTST.
  - Port 1 eligible when p1_req=1, cnt1<MAX_OUTST and wr_busy=0.
- AR slot is free when m_arvalid=0, or when m_arvalid=1 and m_arready=1 (back-to-back issue allowed).
- Grant, combinational:
  - Only when the slot is free.
  - Fixed priority: port 1 over port 0.
  - Granted port sees pN_addr_ok=1 in the same cycle. The other port's addr_ok is 0.
- On grant, at the next edge:
  - m_arvalid←1; m_araddr←addr; m_arsize←{1'b0,size}; m_arid←ID of the granted port.
  - cntN increments.
- AR hold: while m_arvalid=1 and m_arready=0, m_arid/m_araddr/m_arsize are stable and no new addr_ok is issued.
- If the slot frees with no grant, m_arvalid←0 at the next edge.
- R beat (m_rvalid=1; single-beat, m_rlast treated as 1):
  - m_rid==ID_P0: next cycle p0_data_ok=1, p0_rdata=m_rdata, cnt0 decrements.
  - m_rid==ID_P1: same for port 1.
  - Other RID: beat consumed, rid_err←1 (held until reset), no counter change.
- data_ok is a one-cycle pulse; rdata holds its value until the next data_ok for that port.
- Grant and return for the same port in the same cycle leave the counter unchanged.
- Counter at 0 with a matching return: underflow. Counter stays at 0 and rid_err←1.
- wr_busy rising while a port 1 AR is already in m_arvalid does not cancel it.
- Latency:
  - addr_ok → m_arvalid: 1 cycle.
  - R handshake → data_ok: 1 cycle.
  - Returns are delivered in R order; per-ID in-order is guaranteed by AXI.

Optional Feature:
- Macro RR_ARB_EN.
- Defined:
  - Round-robin between eligible ports. A 1-bit pointer holds the last granted port; the other port wins when both are eligible.
  - Pointer updates on every grant; reset value 0, so port 1 wins the first tie.
  - wr_busy gating is unchanged.
- Undefined: fixed port-1 priority as above; no pointer register.

Test Plan:
- Single read: p0_req=1, addr=0x1C000000, size=2 → p0_addr_ok same cycle; next cycle m_arvalid=1, m_arid=0, m_arsize=3'b010. Hold m_arready=0 for 3 cycles → fields stable. Return m_rid=0, m_rdata=0xDEADBEEF → p0_data_ok=1 one cycle later with that data.
- Contention: p0_req=p1_req=1 every cycle, m_arready=1 → without RR_ARB_EN, port 1 granted until cnt1=2, then port 0. With RR_ARB_EN, grants alternate 1,0,1,0.
- Outstanding limit: MAX_OUTST=2, no R returns, p1_req held → exactly 2 p1_addr_ok pulses. Return one RID=1 beat → third p1_addr_ok within 2 cycles.
- Write ordering: wr_busy=1, p1_req=1, p0_req=1 → only port 0 granted. Drop wr_busy → port 1 granted next free slot.
- Interleaved returns: issue p0 then p1; return RID=1 (0x11111111) then RID=0 (0x22222222) → p1_data_ok then p0_data_ok with matching data, both counters back to 0.
- Errors/reset: return m_rid=5 → rid_err=1, counters unchanged. Assert rst_n=0 mid-transaction → all outputs to reset values immediately, without waiting for a clock edge.
